sdram_burst_read: RTL and testbench
===================================

SDRAM_BURST_READ -- requirements
Module: sdram_burst_read

Interface
REQ-001 Parameter TRCD_CLK, default 2, sets the ACTIVE-to-READ wait in clk cycles.
REQ-002 Parameter CAS_LAT, default 3, sets the CAS latency in clk cycles and SHALL match the device mode register.
REQ-003 Parameter TRP_CLK, default 2, sets the PRECHARGE-to-idle wait in clk cycles.
REQ-004 clk  input  1  100 MHz system clock; every flop is rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 init_end  input  1  SDRAM initialisation complete; level-sensitive.
REQ-007 rd_en  input  1  arbiter grant to start one read burst.
REQ-008 rd_addr  input  24  {bank[23:22], row[21:9], col[8:0]}.
REQ-009 rd_burst_len  input  10  number of 16-bit words to read.
REQ-010 sdram_dq_in  input  16  SDRAM data bus, sampled on clk.
REQ-011 rd_cmd  output  4  {cs_n,ras_n,cas_n,we_n} command.
REQ-012 rd_ban  output  2  SDRAM bank address.
REQ-013 rd_sdram_addr  output  13  SDRAM row/column address.
REQ-014 rd_ack  output  1  high while rd_sdram_data holds a valid word.
REQ-015 rd_sdram_data  output  16  registered read data.
REQ-016 rd_end  output  1  one-cycle pulse when the burst and precharge are complete.

Function
REQ-017 The command encodings SHALL be: NOP 0111, ACTIVE 0011, READ 0101, BURST_STOP 0110, PRECHARGE 0010.
REQ-018 The FSM SHALL have the states IDLE, ACT, TRCD, RD, CL_RD (data phase), PRE, TRP and END.
REQ-019 In IDLE, rd_en=1 with init_end=1 SHALL move the FSM to ACT; otherwise it SHALL stay in IDLE with NOP on rd_cmd.
REQ-020 ACT SHALL drive ACTIVE for one cycle with ban=rd_addr[23:22] and addr=rd_addr[21:9].
REQ-021 TRCD SHALL drive NOP for TRCD_CLK-1 cycles.
REQ-022 RD (cycle T0) SHALL drive READ for one cycle with ban=bank and addr={4'b0000, rd_addr[8:0]}.
REQ-023 Words are read in page-burst mode:
  - word k SHALL appear on sdram_dq_in at T0+CAS_LAT+k;
  - BURST_STOP SHALL be issued at T0+L, where L is the effective burst length.
REQ-024 rd_sdram_data SHALL register word k at T0+CAS_LAT+k+1, and rd_ack SHALL be high in exactly those L cycles.
REQ-025 PRECHARGE SHALL be issued in the cycle after the last rd_ack and is followed by TRP_CLK-1 NOP cycles.
REQ-026 END SHALL pulse rd_end for one cycle and then return to IDLE.
REQ-027 Effective length L SHALL be: rd_burst_len=0 -> 1; rd_burst_len>512 -> 512; otherwise rd_burst_len.
REQ-028 The column SHALL wrap within the open row (511 -> 0); no row crossing occurs.
REQ-029 rd_addr and rd_burst_len SHALL be captured in IDLE on the start cycle; later changes SHALL be ignored.
REQ-030 rd_en deasserting mid-burst SHALL be ignored and the burst SHALL complete.
REQ-031 rd_en still high in END SHALL NOT retrigger until the FSM is back in IDLE.
REQ-032 The data-phase counter SHALL be 10 bits wide and SHALL clear on entry to every state.

Reset
REQ-033 While rst_n=0, the outputs SHALL be: FSM IDLE, rd_cmd=0111, rd_ban=2'b11, rd_sdram_addr=13'h1FFF, rd_ack=0, rd_sdram_data=0, rd_end=0, counters=0.
REQ-034 Reset asserted mid-burst SHALL abort immediately with no PRECHARGE; the controller re-initialises the SDRAM.

Configuration
REQ-035 Macro SDRAM_RD_PRE_ALL_EN SHALL select the precharge form:
  - defined: PRECHARGE drives addr[10]=1 (all banks), ban=2'b11;
  - undefined: PRECHARGE drives addr[10]=0, ban=captured bank;
  - in both cases all other addr bits SHALL be 0.

Verification
REQ-036 Defaults, len=10, addr=24'h000000, model preloaded 0..9:
  - ACTIVE@A, READ@A+2, BURST_STOP@A+12, rd_ack on A+6..A+15 carrying data 0..9;
  - PRECHARGE@A+16, rd_end@A+18.
REQ-037 len=0 -> exactly one rd_ack carrying word 0, and BURST_STOP at T0+1.
REQ-038 addr col=9'd510, len=4 -> data sequence is cols 510, 511, 0, 1, all in the same row.
REQ-039 init_end=0 with rd_en=1 for 50 cycles -> rd_cmd stays 0111 and no rd_ack; the burst starts once init_end=1.
REQ-040 rst_n pulsed low at T0+5 -> next cycle rd_cmd=0111, rd_ack=0, state IDLE; a following rd_en runs a clean burst.
REQ-041 Compile with and without SDRAM_RD_PRE_ALL_EN, bank=2 -> PRECHARGE addr[10]/ban = 1/11 and 0/10 respectively.

Source files
------------

// File: rtl/sdram_burst_read.sv
// rtl/sdram_burst_read.sv - SDRAM page-burst read sequencer; SDRAM_RD_PRE_ALL_EN selects precharge-all.
module sdram_burst_read #(
    parameter int TRCD_CLK = 2,
    parameter int CAS_LAT  = 3,
    parameter int TRP_CLK  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_end,
    input  logic        rd_en,
    input  logic [23:0] rd_addr,
    input  logic [9:0]  rd_burst_len,
    input  logic [15:0] sdram_dq_in,
    output logic [3:0]  rd_cmd,
    output logic [1:0]  rd_ban,
    output logic [12:0] rd_sdram_addr,
    output logic        rd_ack,
    output logic [15:0] rd_sdram_data,
    output logic        rd_end
);

    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_READ       = 4'b0101;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_TRCD, S_RD, S_CL_RD, S_PRE, S_TRP, S_END
    } state_t;

    state_t      state, state_next;
    logic [9:0]  cnt;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    logic [9:0]  burst_len;
    logic [9:0]  len_eff;
    logic        start;
    logic        sample;
    logic [10:0] cnt_ext;
    logic [10:0] stop_cnt;
    logic [10:0] data_last;

    assign start     = (state == S_IDLE) && rd_en && init_end;
    assign len_eff   = (rd_burst_len == 10'd0)   ? 10'd1   :
                       (rd_burst_len > 10'd512)  ? 10'd512 : rd_burst_len;
    assign cnt_ext   = {1'b0, cnt};
    assign stop_cnt  = {1'b0, burst_len} - 11'd1;
    // CL_RD counts from T0+1, so its last cycle (holding the final word) is cnt = CAS_LAT+L-1
    assign data_last = 11'(CAS_LAT) + {1'b0, burst_len} - 11'd1;
    assign sample    = (state == S_CL_RD) && (cnt_ext >= 11'(CAS_LAT - 1)) && (cnt_ext < data_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_ACT;
            S_ACT:   state_next = (TRCD_CLK > 1) ? S_TRCD : S_RD;
            S_TRCD:  if (cnt == 10'(TRCD_CLK - 2)) state_next = S_RD;
            S_RD:    state_next = S_CL_RD;
            S_CL_RD: if (cnt_ext == data_last) state_next = S_PRE;
            S_PRE:   state_next = (TRP_CLK > 1) ? S_TRP : S_END;
            S_TRP:   if (cnt == 10'(TRP_CLK - 2)) state_next = S_END;
            S_END:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_cmd        = CMD_NOP;
        rd_ban        = 2'b11;
        rd_sdram_addr = 13'h1FFF;
        case (state)
            S_ACT: begin
                rd_cmd        = CMD_ACTIVE;
                rd_ban        = bank;
                rd_sdram_addr = row;
            end
            S_RD: begin
                rd_cmd        = CMD_READ;
                rd_ban        = bank;
                rd_sdram_addr = {4'b0000, col};
            end
            S_CL_RD: begin
                if (cnt_ext == stop_cnt) rd_cmd = CMD_BURST_STOP;
            end
            S_PRE: begin
                rd_cmd = CMD_PRECHARGE;
`ifdef SDRAM_RD_PRE_ALL_EN
                rd_ban        = 2'b11;
                rd_sdram_addr = 13'h0400;
`else
                rd_ban        = bank;
                rd_sdram_addr = 13'h0000;
`endif
            end
            default: ;
        endcase
    end

    assign rd_end = (state == S_END);

    // Counter restarts on every state change so each wait is measured from its own entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 10'd0;
        end else if (state_next != state) begin
            cnt <= 10'd0;
        end else if (state != S_IDLE) begin
            cnt <= cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank      <= 2'd0;
            row       <= 13'd0;
            col       <= 9'd0;
            burst_len <= 10'd1;
        end else if (start) begin
            bank      <= rd_addr[23:22];
            row       <= rd_addr[21:9];
            col       <= rd_addr[8:0];
            burst_len <= len_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack        <= 1'b0;
            rd_sdram_data <= 16'd0;
        end else begin
            rd_ack <= sample;
            if (sample) rd_sdram_data <= sdram_dq_in;
        end
    end

endmodule

// File: tb/tb_sdram_burst_read.sv
// tb/tb_sdram_burst_read.sv - directed bench for sdram_burst_read with a page-burst SDRAM read model.
module tb_sdram_burst_read;

    localparam int CAS = 3;

    logic        clk;
    logic        rst_n;
    logic        init_end;
    logic        rd_en;
    logic [23:0] rd_addr;
    logic [9:0]  rd_burst_len;
    logic [15:0] sdram_dq_in;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ban;
    logic [12:0] rd_sdram_addr;
    logic        rd_ack;
    logic [15:0] rd_sdram_data;
    logic        rd_end;

    sdram_burst_read dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_end      (init_end),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_burst_len  (rd_burst_len),
        .sdram_dq_in   (sdram_dq_in),
        .rd_cmd        (rd_cmd),
        .rd_ban        (rd_ban),
        .rd_sdram_addr (rd_sdram_addr),
        .rd_ack        (rd_ack),
        .rd_sdram_data (rd_sdram_data),
        .rd_end        (rd_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    int act_q[$];
    int rd_q[$];
    int bs_q[$];
    int pre_q[$];
    int end_q[$];
    int ack_c[$];
    logic [15:0] ack_d[$];
    int n_other = 0;
    logic [12:0] act_row = 13'd0;
    logic [1:0]  act_ban = 2'd0;
    logic [12:0] pre_addr = 13'd0;
    logic [1:0]  pre_ban = 2'd0;
    int t0 = -1000;
    int stop_c = -1;
    int rd_col = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Command monitor plus SDRAM model: word k driven during cycle T0+CAS+k until truncated by BURST_STOP
    always @(negedge clk) begin
        int k;
        case (rd_cmd)
            4'b0011: begin act_q.push_back(cyc); act_row = rd_sdram_addr; act_ban = rd_ban; end
            4'b0101: begin rd_q.push_back(cyc); t0 = cyc; stop_c = -1; rd_col = int'(rd_sdram_addr[8:0]); end
            4'b0110: begin bs_q.push_back(cyc); stop_c = cyc; end
            4'b0010: begin pre_q.push_back(cyc); pre_addr = rd_sdram_addr; pre_ban = rd_ban; end
            4'b0111: ;
            default: n_other++;
        endcase
        if (rd_ack) begin ack_c.push_back(cyc); ack_d.push_back(rd_sdram_data); end
        if (rd_end) end_q.push_back(cyc);
        k = cyc - t0 - CAS;
        if (k >= 0 && (stop_c < 0 || k < stop_c - t0))
            sdram_dq_in = {act_row[6:0], 9'((rd_col + k) % 512)};
        else
            sdram_dq_in = 16'hDEAD;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        act_q.delete(); rd_q.delete(); bs_q.delete(); pre_q.delete();
        end_q.delete(); ack_c.delete(); ack_d.delete(); n_other = 0;
    endtask

    task automatic start(input logic [23:0] a, input logic [9:0] l);
        tick();
        rd_addr = a; rd_burst_len = l; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rd_addr = 24'hFFFFFF; rd_burst_len = 10'h155;
    endtask

    task automatic wait_ends(input int n, input int budget);
        int b = 0;
        while (end_q.size() < n && b < budget) begin tick(); b++; end
        checks++;
        if (end_q.size() < n) $display("FAIL wait_end: got %0d rd_end pulses, need %0d", end_q.size(), n);
        else passes++;
    endtask

    task automatic check_data(input string name, input int n, input logic [15:0] row_tag, input int col0);
        int bad = 0;
        logic [15:0] exp;
        checks++;
        for (int i = 0; i < ack_d.size() && i < n; i++) begin
            exp = row_tag | 16'((col0 + i) % 512);
            if (ack_d[i] !== exp && bad == 0) begin
                $display("FAIL %s: word %0d got %h expected %h", name, i, ack_d[i], exp);
                bad++;
            end
        end
        if (ack_d.size() != n) $display("FAIL %s_count: got %0d acks expected %0d", name, ack_d.size(), n);
        else if (bad == 0) passes++;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init_end = 1'b1; rd_en = 1'b0; rd_addr = 24'd0; rd_burst_len = 10'd0;
        repeat (3) tick();
        chk("rst_cmd", rd_cmd, 4'b0111);
        chk("rst_ban", rd_ban, 2'b11);
        chk("rst_addr", rd_sdram_addr, 13'h1FFF);
        chk("rst_ack", rd_ack, 0);
        chk("rst_data", rd_sdram_data, 0);
        chk("rst_end", rd_end, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int a;
        clear_log();
        start(24'h000000, 10'd10);
        wait_ends(1, 100);
        a = (act_q.size() > 0) ? act_q[0] : 0;
        chk("basic_read", (rd_q.size() > 0) ? rd_q[0] - a : -1, 2);
        chk("basic_bstop", (bs_q.size() > 0) ? bs_q[0] - a : -1, 12);
        chk("basic_ack_first", (ack_c.size() > 0) ? ack_c[0] - a : -1, 6);
        chk("basic_ack_last", (ack_c.size() > 0) ? ack_c[ack_c.size()-1] - a : -1, 15);
        chk("basic_pre", (pre_q.size() > 0) ? pre_q[0] - a : -1, 16);
        chk("basic_end", (end_q.size() > 0) ? end_q[0] - a : -1, 18);
        check_data("basic_data", 10, 16'h0000, 0);
        repeat (3) tick();
        chk("basic_end_pulses", end_q.size(), 1);
    endtask

    task automatic test_len_zero();
        clear_log();
        start(24'h000000, 10'd0);
        wait_ends(1, 100);
        check_data("len0_data", 1, 16'h0000, 0);
        chk("len0_bstop", (bs_q.size() > 0 && rd_q.size() > 0) ? bs_q[0] - rd_q[0] : -1, 1);
    endtask

    task automatic test_len_clamp();
        clear_log();
        start(24'h000000, 10'd1000);
        wait_ends(1, 1500);
        check_data("clamp_data", 512, 16'h0000, 0);
        chk("clamp_bstop", (bs_q.size() > 0 && rd_q.size() > 0) ? bs_q[0] - rd_q[0] : -1, 512);
    endtask

    task automatic test_col_wrap();
        clear_log();
        start({2'b01, 13'd5, 9'd510}, 10'd4);
        wait_ends(1, 100);
        check_data("wrap_data", 4, 16'(5 << 9), 510);
        chk("wrap_one_active", act_q.size(), 1);
        chk("wrap_row", act_row, 5);
        chk("wrap_ban", act_ban, 1);
    endtask

    task automatic test_init_end();
        int b = 0;
        clear_log();
        init_end = 1'b0;
        tick();
        rd_addr = 24'd0; rd_burst_len = 10'd2; rd_en = 1'b1;
        repeat (50) tick();
        chk("init_cmds", act_q.size() + rd_q.size() + bs_q.size() + pre_q.size() + n_other, 0);
        chk("init_acks", ack_c.size(), 0);
        init_end = 1'b1;
        while (act_q.size() < 2 && b < 100) begin tick(); b++; end
        rd_en = 1'b0;
        wait_ends(2, 100);
        chk("end_no_retrigger", (act_q.size() > 1 && end_q.size() > 0) ? act_q[1] - end_q[0] : -1, 2);
        chk("init_ack_total", ack_c.size(), 4);
    endtask

    task automatic test_reset_mid();
        int b = 0;
        clear_log();
        start(24'h000000, 10'd20);
        while (rd_q.size() < 1 && b < 50) begin tick(); b++; end
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd", rd_cmd, 4'b0111);
        tick();
        chk("mid_rst_cmd_next", rd_cmd, 4'b0111);
        chk("mid_rst_ack", rd_ack, 0);
        chk("mid_rst_end", rd_end, 0);
        chk("mid_rst_no_pre", pre_q.size(), 0);
        rst_n = 1'b1;
        tick();
        clear_log();
        start(24'h000000, 10'd3);
        wait_ends(1, 100);
        check_data("mid_rst_after", 3, 16'h0000, 0);
        chk("mid_rst_after_pre", pre_q.size(), 1);
    endtask

    task automatic test_precharge_form();
        clear_log();
        start({2'b10, 13'd7, 9'd3}, 10'd3);
        wait_ends(1, 100);
`ifdef SDRAM_RD_PRE_ALL_EN
        chk("pre_a10", pre_addr[10], 1);
        chk("pre_ban", pre_ban, 2'b11);
`else
        chk("pre_a10", pre_addr[10], 0);
        chk("pre_ban", pre_ban, 2'b10);
`endif
        chk("pre_other_bits", pre_addr & 13'h1BFF, 0);
        check_data("pre_data", 3, 16'(7 << 9), 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_len_clamp();
        test_col_wrap();
        test_init_end();
        test_reset_mid();
        test_precharge_form();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
